// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: shared definitions for the UART receive deframer and the TX
// command FSM.
//   - uart_state_e : receiver state encoding (IDLE/START/DATA/STOP)
//   - RATE_*       : ASCII bit-rate select codes ('1', '5', 'A')
//   - CMD_*        : ASCII command characters (m/M, f/F, c/C)
//   - is_rate_code : true when a byte is one of the three rate codes
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Width of the oversample divisor counter.
    localparam int DIV_W = 16;

    localparam logic [7:0] RATE_1 = 8'h31;
    localparam logic [7:0] RATE_5 = 8'h35;
    localparam logic [7:0] RATE_A = 8'h41;

    localparam logic [7:0] CMD_M_UP = 8'h4D;
    localparam logic [7:0] CMD_M_LO = 8'h6D;
    localparam logic [7:0] CMD_F_UP = 8'h46;
    localparam logic [7:0] CMD_F_LO = 8'h66;
    localparam logic [7:0] CMD_C_UP = 8'h43;
    localparam logic [7:0] CMD_C_LO = 8'h63;

    function automatic logic is_rate_code(input logic [7:0] code);
        return (code == RATE_1) || (code == RATE_5) || (code == RATE_A);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick: divisor counter producing a one-cycle tick every DIV clocks.
//   clk   in  system clock
//   reset in  asynchronous active-low reset
//   clr   in  restart the count at 0 on the next clock
//   div   in  clocks per tick (expected >= 2)
//   tick  out high while the counter sits at div-1
// ---------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // >= rather than == so that a divisor shrinking while the count is
    // above the new terminal value wraps immediately instead of running
    // through the full counter range.
    assign tick = (cnt_q >= (div - DIV_W'(1)));

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer: 8N1 UART receiver with 16x oversampling.
//   clk        in  system clock
//   reset      in  asynchronous active-low reset
//   iRX        in  asynchronous serial line, idle high
//   iRATE      in  ASCII rate code ('1', '5', 'A'); sampled only in IDLE
//   oDATA      out last correctly framed byte, held until the next good frame
//   oVALID     out one-cycle strobe when oDATA updates
//   oFRAME_ERR out one-cycle strobe when the stop bit is sampled low
//   oBUSY      out high from start detection until return to IDLE
//   oDBG_STATE out current receiver state (uart_state_e encoding)
//
// Output strobes: oVALID and oFRAME_ERR are mutually exclusive, last exactly
// one cycle, carry no back-pressure, and oDATA is stable while oVALID is high.
// ---------------------------------------------------------------------------
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int OVS_DIV_1 = 326,
    parameter int OVS_DIV_5 = 54,
    parameter int OVS_DIV_A = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iRX,
    input  logic [7:0] iRATE,
    output logic [7:0] oDATA,
    output logic       oVALID,
    output logic       oFRAME_ERR,
    output logic       oBUSY,
    output logic [1:0] oDBG_STATE
);

    uart_state_e      state_q, state_d;
    logic             rx_s1_q, rx_s2_q;
    logic [7:0]       rate_q, rate_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             armed_q, armed_d;

    logic [DIV_W-1:0] div;
    logic             tick;
    logic             rx_sync;
    logic             start_det;
    logic             mid_start;
    logic             data_sample;
    logic             stop_sample;
    logic             busy;

    assign rx_sync = rx_s2_q;

    always_comb begin
        case (rate_q)
            RATE_5:  div = DIV_W'(OVS_DIV_5);
            RATE_A:  div = DIV_W'(OVS_DIV_A);
            default: div = DIV_W'(OVS_DIV_1);
        endcase
    end

    // Divider restarts on the start edge so every sample point is measured
    // from the detected falling edge.
    uart_baud_tick u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (start_det),
        .div   (div),
        .tick  (tick)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_det) state_d = ST_START;
            ST_START: if (mid_start) state_d = rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:  if (data_sample && (bitcnt_q == 3'd7)) state_d = ST_STOP;
            ST_STOP:  if (stop_sample) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / decode ----------------
    always_comb begin
        busy        = (state_q != ST_IDLE);
        start_det   = (state_q == ST_IDLE) && armed_q && !rx_sync;
        mid_start   = (state_q == ST_START) && tick && (tcnt_q == 4'd7);
        data_sample = (state_q == ST_DATA) && tick && (tcnt_q == 4'd15);
        stop_sample = (state_q == ST_STOP) && tick && (tcnt_q == 4'd15);
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        rate_d   = rate_q;
        tcnt_d   = tcnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        armed_d  = armed_q;

        if ((state_q == ST_IDLE) && is_rate_code(iRATE)) begin
            rate_d = iRATE;
        end

        // Tick count: 0 on start detection and at mid start bit, so DATA
        // and STOP see their 16th tick at mid-bit.
        if (start_det || mid_start) begin
            tcnt_d = 4'd0;
        end else if (busy && tick) begin
            tcnt_d = tcnt_q + 4'd1;
        end

        if (mid_start) begin
            bitcnt_d = 3'd0;
        end else if (data_sample) begin
            bitcnt_d = bitcnt_q + 3'd1;
        end

        // LSB first: each new bit enters at the top and moves down.
        if (data_sample) begin
            shift_d = {rx_sync, shift_q[7:1]};
        end

        if (stop_sample) begin
            if (rx_sync) begin
                valid_d = 1'b1;
                data_d  = shift_q;
            end else begin
                ferr_d  = 1'b1;
            end
        end

        // A framing error disarms until the line has been seen idle again,
        // so a stuck-low line cannot produce a stream of bogus frames.
        if (stop_sample && !rx_sync) begin
            armed_d = 1'b0;
        end else if (rx_sync) begin
            armed_d = 1'b1;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q  <= 1'b1;
            rx_s2_q  <= 1'b1;
            rate_q   <= RATE_1;
            tcnt_q   <= 4'd0;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            rx_s1_q  <= iRX;
            rx_s2_q  <= rx_s1_q;
            rate_q   <= rate_d;
            tcnt_q   <= tcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            armed_q  <= armed_d;
        end
    end

    assign oDATA      = data_q;
    assign oVALID     = valid_q;
    assign oFRAME_ERR = ferr_q;
    assign oBUSY      = busy;
    assign oDBG_STATE = state_q;

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Serial receiver that recovers 8N1 UART frames from the board RX pin and delivers one byte per frame, with a single-cycle valid strobe, to the TX command FSM's `idata` path. The command FSM decodes mode characters (`m`/`M`, `f`/`F`, `c`/`C`) and rate characters (`1`, `5`, `A`). The bit-rate is selected by the same ASCII rate code that the TX side uses, so both directions switch together.

## Interface
- `OVS_DIV_1`, default 326: clocks per 16x-oversample tick for rate code `1` (9600 baud @ 50 MHz).
- `OVS_DIV_5`, default 54: clocks per tick for rate code `5` (57600 baud).
- `OVS_DIV_A`, default 27: clocks per tick for rate code `A` (115200 baud).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `iRX`  in  1  asynchronous serial line, idle high.
- `iRATE`  in  8  ASCII rate code: 0x31 `1`, 0x35 `5`, 0x41 `A`.
- `oDATA`  out  8  last correctly framed byte, held until the next good frame.
- `oVALID`  out  1  one-cycle pulse when `oDATA` updates.
- `oFRAME_ERR`  out  1  one-cycle pulse when the stop bit is sampled low.
- `oBUSY`  out  1  high from start detection until return to IDLE.

## Operation
- `iRX` passes through a 2-flop synchronizer. Both flops reset to 1.
- Rate register:
  - Reset value selects code 0x31.
  - In IDLE only, it loads `iRATE` when `iRATE` is 0x31, 0x35 or 0x41. Any other value holds the previous rate.
  - A change of `iRATE` mid-frame has no effect until the next IDLE.
- Tick generator counts 0..DIV-1 and emits `tick` on DIV-1. It is cleared on entry to START.
- State machine states: IDLE, START, DATA, STOP.
  - IDLE: the receiver is armed only after the synchronized line has been seen high at least once since reset or since a framing error. When armed, synchronized line low → START, and `oBUSY` goes high.
  - START: on the 8th tick (mid start bit), sample the line.
    - Low: go to DATA and clear the bit and tick counts.
    - High: treat as a glitch. Go to IDLE with no output pulses.
  - DATA: every 16th tick, sample one bit into a shift register, LSB first. After bit 7 → STOP.
  - STOP: on the 16th tick, sample the line.
    - High: load the shift register into `oDATA` and pulse `oVALID`.
    - Low: pulse `oFRAME_ERR`, leave `oDATA` unchanged, and disarm.
    - Either way → IDLE.
- Only one stop bit is checked. A new start bit may begin immediately after the stop-bit sample, so back-to-back frames are supported.
- `oVALID` and `oFRAME_ERR` are never high in the same cycle.

## Timing
- Reset values: `oDATA`=0x00, `oVALID`=0, `oFRAME_ERR`=0, `oBUSY`=0, state IDLE, rate code 0x31.
- Reset asserted mid-frame returns the block to IDLE immediately. No pulse is produced for the partial frame.
- Synchronizer latency is 2 clocks.
- Start-edge-to-first-data-sample is 24 ticks (8 + 16).
- `oVALID`/`oFRAME_ERR` are registered and assert on the clock after the stop-bit sample tick, for exactly one cycle.
- `oBUSY` falls in the same cycle that `oVALID` or `oFRAME_ERR` rises.
- One bit time is 16×DIV clocks: 5216 at code `1`, 864 at `5`, 432 at `A`.
- Tolerated baud mismatch is ±3 % (mid-bit sampling).

## Structure
- Shared package `uart_pkg` holds:
  - the state encoding (IDLE/START/DATA/STOP);
  - rate code constants 0x31/0x35/0x41;
  - command character constants: 0x4D/0x6D, 0x46/0x66, 0x43/0x63.
  
  The TX command FSM uses the same package.
- One sub-module, `uart_baud_tick`: a divisor counter with `clk`, `reset`, a clear input, a divisor input and a `tick` output. It is reusable by the TX serializer.
- The rate decode, synchronizer, FSM and shift register are in the top level.

## Test plan
- Default rate: send 0x4D with a good stop bit → exactly one `oVALID` pulse, `oDATA`=0x4D, `oFRAME_ERR`=0, `oBUSY` high for ~9.5 bit times.
- Glitch: hold `iRX` low for 3 ticks (978 clocks) at rate `1` → no pulses, return to IDLE, then a following 0x66 frame is received correctly.
- Framing error: after 0x4D, send 0x46 with the stop bit low, then hold the line low for 2 bit times → one `oFRAME_ERR` pulse, `oDATA` stays 0x4D, no start is detected until the line goes high.
- Rate switch:
  - Set `iRATE`=0x41 in IDLE, send 0x63 at 115200 → `oDATA`=0x63.
  - Change `iRATE` to 0x35 during the next frame (0x43 at 115200) → that frame still decodes as 0x43.
  - Set `iRATE`=0x7A → the rate is unchanged.
- Reset mid-frame: assert `reset` during data bit 4 → all outputs go to reset values at once. After release, a 0x31 frame at 9600 gives `oDATA`=0x31.
- Back-to-back: send 0x6D then 0x66 with single stop bits at rate `1` → two `oVALID` pulses 52160 clocks apart, with values 0x6D then 0x66.
